// File: rtl/rgb_seq_pkg.sv
// Shared types, palette and helpers for the RGB duty sequencer.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    BREATH = 2'd0,
    FADE   = 2'd1,
    STATIC = 2'd2,
    OFF    = 2'd3
  } mode_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  localparam int PALETTE_LEN = 6;

  // On/off masks {r,g,b}: red, yellow, green, cyan, blue, magenta.
  localparam logic [2:0] PALETTE [PALETTE_LEN] = '{
    3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101
  };

  function automatic mode_e mode_next(input mode_e m);
    case (m)
      BREATH:  return FADE;
      FADE:    return STATIC;
      STATIC:  return OFF;
      default: return BREATH;
    endcase
  endfunction

  function automatic logic [2:0] idx_next(input logic [2:0] i);
    return (i == 3'(PALETTE_LEN - 1)) ? 3'd0 : i + 3'd1;
  endfunction

  // One colour component between two palette entries; never exceeds max_l.
  function automatic logic [7:0] fade_comp(input logic a_on, input logic b_on,
                                           input logic [7:0] max_l,
                                           input logic [7:0] phase);
    logic [15:0] prod;
    prod = {8'd0, max_l} * {8'd0, phase};
    if (a_on == b_on) return a_on ? max_l : 8'd0;
    else if (b_on)    return prod[15:8];
    else              return max_l - prod[15:8];
  endfunction

endpackage

// File: rtl/rgb_fade_seq_sw_debounce.sv
// Push-button conditioning: 2-FF synchroniser plus a consecutive-cycle debouncer.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          differ;
  logic          flip;

  assign differ = sync_q ^ level_q;
  assign flip   = differ && (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= CNT_LOAD;
    end else begin
      sync_1 <= sw;
      sync_q <= sync_1;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (!differ || flip) cnt_q <= CNT_LOAD;
      else                 cnt_q <= cnt_q - 1'b1;
      if (flip) level_q <= sync_q;
    end
  end

  assign level = level_q;
  // Asserted in the cycle whose edge commits the new high level.
  assign rise  = flip && sync_q;

endmodule

// File: rtl/rgb_fade_seq.sv
// RGB duty setpoint sequencer: envelope engine, shadow registers, frame-aligned transfer.
// mode   | meaning
// BREATH | all channels ramp 0..MAX_LEVEL..0 together
// FADE   | interpolate around the six-colour palette
// STATIC | shadow frozen, step_tick ignored
// OFF    | shadow forced to zero
module rgb_fade_seq
  import rgb_seq_pkg::*;
#(
  parameter int MAX_LEVEL       = 128,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_tick,
  input  logic       sw,
  input  logic       frame_done,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       duty_valid,
  output logic [1:0] mode
);

  localparam logic [7:0] MAX_L = 8'(MAX_LEVEL);

  mode_e      mode_q,  mode_d;
  dir_e       dir_q,   dir_d;
  logic [7:0] level_q, level_d;
  logic [2:0] idx_q,   idx_d;
  logic [7:0] phase_q, phase_d;
  logic [7:0] sh_r_q, sh_g_q, sh_b_q;
  logic [7:0] sh_r_d, sh_g_d, sh_b_d;
  logic [2:0] pal_a, pal_b;
  logic       sw_rise;
  logic       sw_level_unused;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .level (sw_level_unused),
    .rise  (sw_rise)
  );

  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    level_d = level_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    sh_r_d  = sh_r_q;
    sh_g_d  = sh_g_q;
    sh_b_d  = sh_b_q;
    pal_a   = 3'b000;
    pal_b   = 3'b000;

    if (sw_rise) begin
      mode_d  = mode_next(mode_q);
      dir_d   = UP;
      level_d = 8'd0;
      idx_d   = 3'd0;
      phase_d = 8'd0;
    end else if (step_tick) begin
      case (mode_q)
        BREATH: begin
          // The turnaround step holds the level for one tick at each end.
          if (dir_q == UP) begin
            if (level_q == MAX_L) dir_d = DOWN;
            else                  level_d = level_q + 8'd1;
          end else begin
            if (level_q == 8'd0)  dir_d = UP;
            else                  level_d = level_q - 8'd1;
          end
          sh_r_d = level_d;
          sh_g_d = level_d;
          sh_b_d = level_d;
        end
        FADE: begin
          phase_d = phase_q + 8'd1;
          if (phase_q == 8'hFF) idx_d = idx_next(idx_q);
          pal_a  = PALETTE[idx_d];
          pal_b  = PALETTE[idx_next(idx_d)];
          sh_r_d = fade_comp(pal_a[2], pal_b[2], MAX_L, phase_d);
          sh_g_d = fade_comp(pal_a[1], pal_b[1], MAX_L, phase_d);
          sh_b_d = fade_comp(pal_a[0], pal_b[0], MAX_L, phase_d);
        end
        default: ;
      endcase
    end

    if (mode_q == OFF) begin
      sh_r_d = 8'd0;
      sh_g_d = 8'd0;
      sh_b_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= BREATH;
      dir_q      <= UP;
      level_q    <= 8'd0;
      idx_q      <= 3'd0;
      phase_q    <= 8'd0;
      sh_r_q     <= 8'd0;
      sh_g_q     <= 8'd0;
      sh_b_q     <= 8'd0;
      duty_r     <= 8'd0;
      duty_g     <= 8'd0;
      duty_b     <= 8'd0;
      duty_valid <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      level_q    <= level_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      sh_r_q     <= sh_r_d;
      sh_g_q     <= sh_g_d;
      sh_b_q     <= sh_b_d;
      duty_valid <= frame_done;
      // The PWM takes the registered shadow, so same-cycle steps land next frame.
      if (frame_done) begin
        duty_r <= sh_r_q;
        duty_g <= sh_g_q;
        duty_b <= sh_b_q;
      end
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_rgb_fade_seq.sv
// Directed self-checking bench for rgb_fade_seq with MAX_LEVEL=4, DEBOUNCE_CYCLES=4.
module tb_rgb_fade_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step_tick = 1'b0;
  logic       sw = 1'b0;
  logic       frame_done = 1'b0;
  logic [7:0] duty_r, duty_g, duty_b;
  logic       duty_valid;
  logic [1:0] mode;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rgb_fade_seq #(.MAX_LEVEL(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .step_tick  (step_tick),
    .sw         (sw),
    .frame_done (frame_done),
    .duty_r     (duty_r),
    .duty_g     (duty_g),
    .duty_b     (duty_b),
    .duty_valid (duty_valid),
    .mode       (mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    step_tick = 1'b1;
    cyc(n);
    step_tick = 1'b0;
  endtask

  task automatic frame();
    frame_done = 1'b1;
    cyc(1);
    frame_done = 1'b0;
  endtask

  task automatic chk_rgb(input string tag, input int r, input int g, input int b);
    chk({tag, "_r"}, 32'(duty_r), 32'(r));
    chk({tag, "_g"}, 32'(duty_g), 32'(g));
    chk({tag, "_b"}, 32'(duty_b), 32'(b));
    chk({tag, "_valid"}, 32'(duty_valid), 32'd1);
  endtask

  task automatic press();
    sw = 1'b1;
    cyc(8);
    sw = 1'b0;
    cyc(8);
  endtask

  int breath_exp [12] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 1, 2};

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("rst_r", 32'(duty_r), 32'd0);
    chk("rst_g", 32'(duty_g), 32'd0);
    chk("rst_b", 32'(duty_b), 32'd0);
    chk("rst_valid", 32'(duty_valid), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);

    // Breathing envelope, one frame per tick.
    for (int i = 0; i < 12; i++) begin
      tick_n(1);
      frame();
      chk_rgb($sformatf("breath%0d", i), breath_exp[i], breath_exp[i], breath_exp[i]);
      cyc(1);
      chk($sformatf("breath%0d_valid_low", i), 32'(duty_valid), 32'd0);
    end

    // Short bounce must not change mode.
    sw = 1'b1;
    cyc(3);
    sw = 1'b0;
    cyc(6);
    chk("bounce_mode", 32'(mode), 32'd0);

    // Held press: sync rise after 2 edges, mode change 4 edges later.
    sw = 1'b1;
    cyc(5);
    chk("press_early_mode", 32'(mode), 32'd0);
    cyc(1);
    chk("press_mode", 32'(mode), 32'd1);
    chk("press_level", 32'(dut.level_q), 32'd0);
    chk("press_idx", 32'(dut.idx_q), 32'd0);
    chk("press_phase", 32'(dut.phase_q), 32'd0);
    sw = 1'b0;
    cyc(8);
    chk("release_mode", 32'(mode), 32'd1);

    // FADE segment 0 midpoint, then the segment wrap.
    tick_n(128);
    frame();
    chk_rgb("fade_mid", 4, 2, 0);
    tick_n(128);
    chk("fade_wrap_idx", 32'(dut.idx_q), 32'd1);
    chk("fade_wrap_phase", 32'(dut.phase_q), 32'd0);
    frame();
    chk_rgb("fade_wrap", 4, 4, 0);
    tick_n(5 * 256);
    chk("fade_loop_idx", 32'(dut.idx_q), 32'd0);
    chk("fade_loop_phase", 32'(dut.phase_q), 32'd0);

    // Phase 63 gives g=0; phase 64 gives g=1.
    tick_n(63);
    frame();
    chk_rgb("fade_p63", 4, 0, 0);
    step_tick = 1'b1;
    frame_done = 1'b1;
    cyc(1);
    step_tick = 1'b0;
    frame_done = 1'b0;
    chk_rgb("simul_old", 4, 0, 0);
    frame();
    chk_rgb("simul_new", 4, 1, 0);

    // STATIC ignores ticks.
    press();
    chk("static_mode", 32'(mode), 32'd2);
    tick_n(10);
    frame();
    chk_rgb("static", 4, 1, 0);

    // OFF forces zero.
    press();
    chk("off_mode", 32'(mode), 32'd3);
    frame();
    chk_rgb("off", 0, 0, 0);

    // Back to BREATH from the bottom.
    press();
    chk("wrap_mode", 32'(mode), 32'd0);
    chk("wrap_level", 32'(dut.level_q), 32'd0);
    tick_n(1);
    frame();
    chk_rgb("wrap_breath", 1, 1, 1);

    // Reset in FADE with a frame_done pending.
    press();
    chk("fade2_mode", 32'(mode), 32'd1);
    tick_n(128);
    frame();
    chk_rgb("fade2", 4, 2, 0);
    frame_done = 1'b1;
    rst = 1'b1;
    cyc(1);
    frame_done = 1'b0;
    chk("mrst_r", 32'(duty_r), 32'd0);
    chk("mrst_g", 32'(duty_g), 32'd0);
    chk("mrst_b", 32'(duty_b), 32'd0);
    chk("mrst_valid", 32'(duty_valid), 32'd0);
    chk("mrst_mode", 32'(mode), 32'd0);
    rst = 1'b0;
    cyc(1);
    chk("mrst_valid_after", 32'(duty_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_fade_seq.md
Name: rgb_fade_seq

Overview:
- Upstream stage of the power-LED PWM driver. Generates the 8-bit per-channel duty setpoints (R, G, B) that the PWM consumes.
- Runs one of four lighting modes and advances on the timer tick.
- A debounced push button cycles the mode.
- New duties are handed to the PWM only at its period boundary, so a PWM period never sees a mid-period duty change.

Parameters:
- MAX_LEVEL, 128, peak duty value and breathing ceiling (1..255).
- DEBOUNCE_CYCLES, 270000, consecutive clk cycles a raw sw level must hold before it is accepted (10 ms at 27 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- step_tick  input  1  one-cycle pulse from the timer; advances the envelope by one step.
- sw  input  1  raw, asynchronous push button, active-high.
- frame_done  input  1  one-cycle pulse from the PWM at a period boundary; the PWM accepts new duties now.
- duty_r  output  8  red duty setpoint.
- duty_g  output  8  green duty setpoint.
- duty_b  output  8  blue duty setpoint.
- duty_valid  output  1  one-cycle pulse; duty_* were updated this cycle.
- mode  output  2  current mode: 0 BREATH, 1 FADE, 2 STATIC, 3 OFF.

Behaviour:
- Clock and reset: single clock, reset is synchronous and active-high.
- Reset values: duty_r/g/b=0, duty_valid=0, mode=BREATH, level=0, dir=UP, idx=0, phase=0, shadow=0, debounced sw=0.
- Button path: sw passes a 2-FF synchroniser, then the sw_debounce sub-module.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A rising edge of the debounced level advances mode: BREATH, FADE, STATIC, OFF, then back to BREATH.
  - Each mode change clears level, dir, idx and phase on the same cycle.
- Envelope engine: updates only on step_tick cycles. Results go to the shadow registers (sh_r/g/b) one cycle after step_tick.
- BREATH mode:
  - sh_r = sh_g = sh_b = level.
  - Going UP: if level==MAX_LEVEL then dir<=DOWN and level holds (one-step dwell); else level+1.
  - Going DOWN: if level==0 then dir<=UP and level holds; else level-1.
  - The full cycle is 2*MAX_LEVEL+2 ticks.
- FADE mode:
  - Palette, from the package: 0 red, 1 yellow, 2 green, 3 cyan, 4 blue, 5 magenta. Each component is 0 or MAX_LEVEL.
  - On step_tick, phase increments 8-bit. When phase==255 it wraps to 0 and idx advances mod 6 (5 wraps to 0).
  - Each component is interpolated from a=pal[idx] to b=pal[idx+1 mod 6]:
    - a==b gives a.
    - 0 to MAX gives (MAX_LEVEL*phase)>>8.
    - MAX to 0 gives MAX_LEVEL-((MAX_LEVEL*phase)>>8).
  - The product is 16 bits, unsigned. No result may exceed MAX_LEVEL.
- STATIC mode: the shadow holds its last value and step_tick is ignored.
- OFF mode: the shadow is forced to 0.
- Transfer handshake:
  - On frame_done, duty_* <= shadow and duty_valid=1 on the next cycle.
  - Without frame_done, duty_* hold and duty_valid=0.
- Simultaneous events:
  - step_tick and frame_done in the same cycle: the output receives the pre-step shadow; the new step is seen at the next frame_done.
  - A mode change and frame_done in the same cycle: the output receives the pre-change shadow.
- Reset mid-operation: every register returns to its reset value on the next edge. No duty_valid pulse accompanies reset.

Decomposition:
- Package rgb_seq_pkg:
  - mode_e enum (BREATH, FADE, STATIC, OFF).
  - dir_e enum (UP, DOWN).
  - PALETTE_LEN=6.
  - Palette constant as 3-bit on/off masks {r,g,b}, scaled by MAX_LEVEL in rgb_fade_seq.
- Sub-module sw_debounce holds the synchroniser and counter, parameterised by DEBOUNCE_CYCLES. Its outputs are the debounced level and a rise pulse.

Test Plan (MAX_LEVEL=4, DEBOUNCE_CYCLES=4):
- Reset, then 12 step_ticks, each followed by a frame_done in BREATH.
  - duty_r per frame: 1,2,3,4,4,3,2,1,0,0,1,2.
  - duty_r=duty_g=duty_b throughout, and one duty_valid per frame_done.
- sw pulses high for 3 cycles, then is held for 6 cycles.
  - The 3-cycle pulse does not change mode.
  - The held press changes mode 0 to 1 exactly 4 cycles after the synchronised rise.
  - Level, idx and phase read 0 after the change.
- In FADE, drive 256 ticks.
  - At phase 128 in segment 0: r=4, g=2, b=0.
  - After the wrap: idx=1, phase=0, output r=4, g=4, b=0.
  - 6*256 ticks return to idx=0.
- step_tick and frame_done asserted in the same cycle.
  - duty_* take the old shadow value.
  - The new value appears only at the following frame_done.
- Cycle to STATIC and send ticks: duty is unchanged. Cycle to OFF: the next frame_done gives 0,0,0. One more press returns to BREATH with level=0.
- Assert rst mid-FADE while frame_done is pending.
  - All outputs are 0 next cycle, with no duty_valid.
  - mode=0 (BREATH).
